// File: rtl/pong_pkg.sv
// Types and defaults shared by the pong match controller, ball and renderer.
// Holds the state encoding, winner codes and the default playfield geometry.
package pong_pkg;

  localparam int DEF_BAR_LENGTH = 180;
  localparam int DEF_D_HEIGHT   = 470;
  localparam int POS_W          = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // Score never climbs past the match limit.
  function automatic logic [3:0] sat_inc(input logic [3:0] p, input logic [3:0] lim);
    return (p >= lim) ? lim : p + 4'd1;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: top-edge position register that moves on a gated strobe and
// clamps to the playfield without wrapping.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int BAR_LENGTH = DEF_BAR_LENGTH,
  parameter int BAR_SPEED  = 3,
  parameter int D_HEIGHT   = DEF_D_HEIGHT
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_stb,
  input  logic             i_up,
  input  logic             i_down,
  output logic [POS_W-1:0] o_top
);

  localparam logic [POS_W-1:0] TOP_MAX = POS_W'(D_HEIGHT - BAR_LENGTH);
  localparam logic [POS_W-1:0] TOP_RST = POS_W'((D_HEIGHT - BAR_LENGTH) / 2);
  localparam logic [POS_W-1:0] SPEED   = POS_W'(BAR_SPEED);

  logic [POS_W-1:0] r_top;
  logic [POS_W-1:0] w_top_next;
  logic [POS_W:0]   w_down_sum;

  // The extra sum bit keeps the lower clamp honest near the 12-bit ceiling.
  always_comb begin
    w_down_sum = {1'b0, r_top} + {1'b0, SPEED};
    w_top_next = r_top;
    if (i_stb && (i_up ^ i_down)) begin
      if (i_up) begin
        w_top_next = (r_top >= SPEED) ? r_top - SPEED : '0;
      end else begin
        w_top_next = (w_down_sum <= {1'b0, TOP_MAX}) ? w_down_sum[POS_W-1:0] : TOP_MAX;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_top <= TOP_RST;
    end else begin
      r_top <= w_top_next;
    end
  end

  assign o_top = r_top;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer for pong: paddles, serve countdown, round start, scoring
// and game-over detection. Every output comes straight from a register.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int BAR_LENGTH   = DEF_BAR_LENGTH,
  parameter int BAR_SPEED    = 3,
  parameter int D_HEIGHT     = DEF_D_HEIGHT,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_POINTS   = 7
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_ani_stb,
  input  logic             in_serve,
  input  logic             in_left_up,
  input  logic             in_left_down,
  input  logic             in_right_up,
  input  logic             in_right_down,
  input  logic             in_left_score,
  input  logic             in_right_score,
  output logic             out_start,
  output logic             out_animate,
  output logic [POS_W-1:0] out_leftbar_top,
  output logic [POS_W-1:0] out_rightbar_top,
  output logic [3:0]       out_left_points,
  output logic [3:0]       out_right_points,
  output logic [1:0]       out_winner,
  output logic [2:0]       out_state
);

  localparam int               CNT_W    = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [3:0]       WIN_PTS  = 4'(WIN_POINTS);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_lp, w_lp_next;
  logic [3:0]       r_rp, w_rp_next;
  logic [1:0]       r_win, w_win_next;
  logic             r_start, w_start_next;
  logic             r_animate, w_animate_next;

  logic             w_pad_stb;
  logic [1:0]       w_up, w_down;
  logic [POS_W-1:0] w_top [2];

  // Paddles are live before and during a rally, frozen once a point is decided.
  assign w_pad_stb = in_ani_stb &&
                     (r_state == ST_IDLE || r_state == ST_SERVE || r_state == ST_PLAY);
  assign w_up      = {in_right_up, in_left_up};
  assign w_down    = {in_right_down, in_left_down};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_paddle
      pong_paddle #(
        .BAR_LENGTH(BAR_LENGTH),
        .BAR_SPEED (BAR_SPEED),
        .D_HEIGHT  (D_HEIGHT)
      ) u_paddle (
        .i_clk (in_clock),
        .i_srst(in_reset),
        .i_stb (w_pad_stb),
        .i_up  (w_up[gi]),
        .i_down(w_down[gi]),
        .o_top (w_top[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_lp_next    = r_lp;
    w_rp_next    = r_rp;
    w_win_next   = r_win;
    w_start_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_serve) begin
          w_state_next = ST_SERVE;
          w_cnt_next   = CNT_LOAD;
        end
      end
      ST_SERVE: begin
        if (in_ani_stb) begin
          w_cnt_next = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = ST_PLAY;
            w_start_next = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // Score flags from the previous round are still up during the start cycle.
        if (!r_start) begin
          if (in_left_score) begin
            w_lp_next    = sat_inc(r_lp, WIN_PTS);
            w_state_next = ST_POINT;
          end else if (in_right_score) begin
            w_rp_next    = sat_inc(r_rp, WIN_PTS);
            w_state_next = ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (r_lp == WIN_PTS) begin
          w_state_next = ST_OVER;
          w_win_next   = WIN_LEFT;
        end else if (r_rp == WIN_PTS) begin
          w_state_next = ST_OVER;
          w_win_next   = WIN_RIGHT;
        end else begin
          w_state_next = ST_SERVE;
          w_cnt_next   = CNT_LOAD;
        end
      end
      ST_OVER: begin
        if (in_serve) begin
          w_state_next = ST_SERVE;
          w_cnt_next   = CNT_LOAD;
          w_lp_next    = '0;
          w_rp_next    = '0;
          w_win_next   = WIN_NONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_animate_next = (w_state_next == ST_PLAY);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lp      <= '0;
      r_rp      <= '0;
      r_win     <= WIN_NONE;
      r_start   <= 1'b0;
      r_animate <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_lp      <= w_lp_next;
      r_rp      <= w_rp_next;
      r_win     <= w_win_next;
      r_start   <= w_start_next;
      r_animate <= w_animate_next;
    end
  end

  assign out_start        = r_start;
  assign out_animate      = r_animate;
  assign out_leftbar_top  = w_top[0];
  assign out_rightbar_top = w_top[1];
  assign out_left_points  = r_lp;
  assign out_right_points = r_rp;
  assign out_winner       = r_win;
  assign out_state        = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: a per-cycle scoreboard of expected outputs plus
// directed spot checks on paddle clamps, serve timing, scoring and reset.
module tb_pong_match_ctrl;

  localparam int SF      = 4;
  localparam int WP      = 7;
  localparam int BL      = 180;
  localparam int BS      = 3;
  localparam int DH      = 470;
  localparam int TMAX    = DH - BL;
  localparam int STB_DIV = 3;

  logic        in_clock = 1'b0;
  logic        in_reset = 1'b1;
  logic        in_ani_stb = 1'b0;
  logic        in_serve = 1'b0;
  logic        in_left_up = 1'b0, in_left_down = 1'b0;
  logic        in_right_up = 1'b0, in_right_down = 1'b0;
  logic        in_left_score = 1'b0, in_right_score = 1'b0;
  logic        out_start, out_animate;
  logic [11:0] out_leftbar_top, out_rightbar_top;
  logic [3:0]  out_left_points, out_right_points;
  logic [1:0]  out_winner;
  logic [2:0]  out_state;

  always #5 in_clock = ~in_clock;

  pong_match_ctrl #(
    .BAR_LENGTH  (BL),
    .BAR_SPEED   (BS),
    .D_HEIGHT    (DH),
    .SERVE_FRAMES(SF),
    .WIN_POINTS  (WP)
  ) dut (
    .in_clock        (in_clock),
    .in_reset        (in_reset),
    .in_ani_stb      (in_ani_stb),
    .in_serve        (in_serve),
    .in_left_up      (in_left_up),
    .in_left_down    (in_left_down),
    .in_right_up     (in_right_up),
    .in_right_down   (in_right_down),
    .in_left_score   (in_left_score),
    .in_right_score  (in_right_score),
    .out_start       (out_start),
    .out_animate     (out_animate),
    .out_leftbar_top (out_leftbar_top),
    .out_rightbar_top(out_rightbar_top),
    .out_left_points (out_left_points),
    .out_right_points(out_right_points),
    .out_winner      (out_winner),
    .out_state       (out_state)
  );

  typedef struct {
    int state; int cnt; int lp; int rp; int win;
    int start; int anim; int ltop; int rtop;
  } mdl_t;

  mdl_t m;
  mdl_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int pad_move(input int top, input logic up, input logic dn);
    if (up && !dn) return (top >= BS) ? top - BS : 0;
    if (dn && !up) return (top + BS <= TMAX) ? top + BS : TMAX;
    return top;
  endfunction

  // Expected outputs after the coming edge, from the inputs now on the pins.
  task automatic model_step();
    mdl_t n;
    n = m;
    n.start = 0;
    if (in_reset) begin
      n = '{0, 0, 0, 0, 0, 0, 0, TMAX / 2, TMAX / 2};
    end else begin
      if (in_ani_stb && m.state <= 2) begin
        n.ltop = pad_move(m.ltop, in_left_up, in_left_down);
        n.rtop = pad_move(m.rtop, in_right_up, in_right_down);
      end
      case (m.state)
        0: if (in_serve) begin n.state = 1; n.cnt = SF; end
        1: if (in_ani_stb) begin
             n.cnt = m.cnt - 1;
             if (m.cnt == 1) begin n.state = 2; n.start = 1; end
           end
        2: if (m.start == 0) begin
             if (in_left_score) begin
               n.lp = (m.lp < WP) ? m.lp + 1 : WP; n.state = 3;
             end else if (in_right_score) begin
               n.rp = (m.rp < WP) ? m.rp + 1 : WP; n.state = 3;
             end
           end
        3: if (m.lp == WP) begin n.state = 4; n.win = 1; end
           else if (m.rp == WP) begin n.state = 4; n.win = 2; end
           else begin n.state = 1; n.cnt = SF; end
        4: if (in_serve) begin
             n.lp = 0; n.rp = 0; n.win = 0; n.state = 1; n.cnt = SF;
           end
        default: ;
      endcase
    end
    n.anim = (n.state == 2) ? 1 : 0;
    m = n;
    exp_q.push_back(n);
  endtask

  task automatic cycle();
    mdl_t e;
    in_ani_stb = (cyc % STB_DIV == 0);
    model_step();
    @(posedge in_clock);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check_val("state",   32'(out_state),        32'(e.state));
    check_val("lpoints", 32'(out_left_points),  32'(e.lp));
    check_val("rpoints", 32'(out_right_points), 32'(e.rp));
    check_val("winner",  32'(out_winner),       32'(e.win));
    check_val("start",   32'(out_start),        32'(e.start));
    check_val("animate", 32'(out_animate),      32'(e.anim));
    check_val("ltop",    32'(out_leftbar_top),  32'(e.ltop));
    check_val("rtop",    32'(out_rightbar_top), 32'(e.rtop));
  endtask

  task automatic wait_state(input int st, input string tag);
    for (int i = 0; i < 200 && int'(out_state) != st; i++) cycle();
    check_val(tag, 32'(out_state), 32'(st));
  endtask

  // Rally that ends with one point; the flag is raised after the start cycle.
  task automatic play_point(input bit left);
    wait_state(2, "wait_play");
    cycle();
    if (left) in_left_score = 1'b1;
    else      in_right_score = 1'b1;
    cycle();
    in_left_score  = 1'b0;
    in_right_score = 1'b0;
  endtask

  initial begin
    int starts;
    m = '{0, 0, 0, 0, 0, 0, 0, TMAX / 2, TMAX / 2};

    repeat (3) cycle();
    in_reset = 1'b0;
    check_val("rst_ltop", 32'(out_leftbar_top), 32'd145);
    check_val("rst_state", 32'(out_state), 32'd0);

    // Paddle clamps while idle.
    in_left_up = 1'b1;
    repeat (100 * STB_DIV) cycle();
    in_left_up = 1'b0;
    check_val("ltop_clamp0", 32'(out_leftbar_top), 32'd0);
    in_right_down = 1'b1;
    repeat (100 * STB_DIV) cycle();
    in_right_down = 1'b0;
    check_val("rtop_clamp", 32'(out_rightbar_top), 32'd290);
    in_right_up = 1'b1; in_right_down = 1'b1;
    repeat (10 * STB_DIV) cycle();
    in_right_up = 1'b0; in_right_down = 1'b0;
    check_val("rtop_both_hold", 32'(out_rightbar_top), 32'd290);

    // Serve; serve stays high through SERVE and PLAY, where it is ignored.
    in_serve = 1'b1;
    cycle();
    check_val("serve_state", 32'(out_state), 32'd1);
    starts = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (out_start === 1'b1) begin
        starts++;
        check_val("anim_with_start", 32'(out_animate), 32'd1);
      end
    end
    in_serve = 1'b0;
    check_val("start_count", 32'(starts), 32'd1);

    // Right scores with the flag held through the next start cycle.
    in_right_score = 1'b1;
    cycle();
    check_val("rscore_pts", 32'(out_right_points), 32'd1);
    check_val("rscore_point", 32'(out_state), 32'd3);
    wait_state(2, "replay");
    cycle();
    in_right_score = 1'b0;
    cycle();
    check_val("no_double", 32'(out_right_points), 32'd1);

    // Simultaneous flags favour left.
    in_left_score = 1'b1; in_right_score = 1'b1;
    cycle();
    in_left_score = 1'b0; in_right_score = 1'b0;
    check_val("both_left", 32'(out_left_points), 32'd1);
    check_val("both_right", 32'(out_right_points), 32'd1);

    // Left runs out the match.
    repeat (WP - 1) play_point(1'b1);
    wait_state(4, "over");
    check_val("winner_left", 32'(out_winner), 32'd1);
    in_left_down = 1'b1; in_right_up = 1'b1;
    repeat (10 * STB_DIV) cycle();
    in_left_down = 1'b0; in_right_up = 1'b0;
    check_val("frozen_l", 32'(out_leftbar_top), 32'd0);
    check_val("frozen_r", 32'(out_rightbar_top), 32'd290);
    in_serve = 1'b1;
    cycle();
    in_serve = 1'b0;
    check_val("new_match_pts", 32'(out_left_points), 32'd0);
    check_val("new_match_win", 32'(out_winner), 32'd0);
    check_val("new_match_st", 32'(out_state), 32'd1);

    // Reset in the middle of a rally at 3/2.
    repeat (3) play_point(1'b1);
    repeat (2) play_point(1'b0);
    wait_state(2, "play_32");
    cycle();
    check_val("pre_rst_lp", 32'(out_left_points), 32'd3);
    check_val("pre_rst_rp", 32'(out_right_points), 32'd2);
    in_reset = 1'b1;
    cycle();
    in_reset = 1'b0;
    check_val("mid_rst_state", 32'(out_state), 32'd0);
    check_val("mid_rst_lp", 32'(out_left_points), 32'd0);
    check_val("mid_rst_ltop", 32'(out_leftbar_top), 32'd145);
    check_val("mid_rst_anim", 32'(out_animate), 32'd0);
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
